// File: rtl/mux41_rr_sched_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux scheduler.
package mux41_sched_pkg;

  localparam int NREQ = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // MUX41X1 pin order puts S1 on the low index bit: returns {s1, s0}.
  function automatic logic [1:0] idx2sel(input logic [1:0] idx);
    return {idx[0], idx[1]};
  endfunction

endpackage

// File: rtl/mux41_rr_sched_if.sv
// Requester-side valid/ready bus plus the single-entry output stage handshake.
interface mux41_rr_sched_if #(
  parameter int W = 8
);
  import mux41_sched_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [1:0]        out_src;
  logic              out_ready;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );

endinterface

// File: rtl/mux41_rr_sched_rr_pick4.sv
// Combinational round-robin pick: first valid index at or after ptr, mod 4.
module rr_pick4 (
  input  logic [3:0] valid,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [3:0] rot;
  logic [1:0] off;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = valid[ptr + 2'(gi)];
    end
  endgenerate

  always_comb begin
    off = 2'd3;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
  end

  assign idx = ptr + off;
  assign any = |valid;

endmodule

// File: rtl/mux41x1.sv
// Behavioural model of the MUX41X1 cell: S1S0 = 00/10/01/11 selects IN1/IN2/IN3/IN4.
module MUX41X1 (
  input  logic IN1,
  input  logic IN2,
  input  logic IN3,
  input  logic IN4,
  input  logic S0,
  input  logic S1,
  output logic Q
);

  assign Q = S0 ? (S1 ? IN4 : IN3) : (S1 ? IN2 : IN1);

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin packet scheduler driving a W-bit bank of MUX41X1 cells into a
// single-entry registered output stage.
module mux41_rr_sched
  import mux41_sched_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mux41_rr_sched_if.slave      bus,
  output logic                 mux_s1,
  output logic                 mux_s0,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_GRANT = GRANT;

  logic [0:0]    state_reg;
  logic [1:0]    ptr_reg;
  logic [1:0]    grant_idx_reg;
  logic [CW-1:0] beat_cnt_reg;
  logic          sel_s1_reg;
  logic          sel_s0_reg;
  logic          out_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic          out_last_reg;
  logic [1:0]    out_src_reg;

  logic [1:0]    pick_idx;
  logic          pick_any;
  logic [W-1:0]  mux_q;
  logic [3:0]    ready_next;
  logic          can_load;
  logic          xfer;
  logic          last_beat;

  rr_pick4 u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mux
      MUX41X1 u_mux (
        .IN1 (bus.req_data[0*W + gi]),
        .IN2 (bus.req_data[1*W + gi]),
        .IN3 (bus.req_data[2*W + gi]),
        .IN4 (bus.req_data[3*W + gi]),
        .S0  (sel_s0_reg),
        .S1  (sel_s1_reg),
        .Q   (mux_q[gi])
      );
    end
  endgenerate

  assign can_load  = !out_valid_reg || bus.out_ready;
  assign xfer      = (state_reg == S_GRANT) && bus.req_valid[grant_idx_reg] && can_load;
  assign last_beat = bus.req_last[grant_idx_reg] || (beat_cnt_reg == CW'(MAX_BURST - 1));

  always_comb begin
    ready_next = '0;
    if (state_reg == S_GRANT) ready_next[grant_idx_reg] = can_load;
  end

  // Arbitration and grant tracking; selects stay put after a packet closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      grant_idx_reg <= '0;
      beat_cnt_reg  <= '0;
      sel_s1_reg    <= 1'b0;
      sel_s0_reg    <= 1'b0;
    end else if (state_reg == S_IDLE) begin
      if (pick_any) begin
        grant_idx_reg            <= pick_idx;
        {sel_s1_reg, sel_s0_reg} <= idx2sel(pick_idx);
        beat_cnt_reg             <= '0;
        state_reg                <= S_GRANT;
      end
    end else if (xfer) begin
      beat_cnt_reg <= beat_cnt_reg + CW'(1);
      if (last_beat) begin
        ptr_reg   <= grant_idx_reg + 2'd1;
        state_reg <= S_IDLE;
      end
    end
  end

  // Output stage: a load may coincide with a drain for back-to-back beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= mux_q;
      out_last_reg  <= last_beat;
      out_src_reg   <= grant_idx_reg;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.req_ready = ready_next;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_src   = out_src_reg;
  assign mux_s1        = sel_s1_reg;
  assign mux_s0        = sel_s0_reg;
  assign busy          = (state_reg == S_GRANT);

endmodule

// File: tb/tb_mux41_rr_sched.sv
// Directed bench for mux41_rr_sched: a vector table for round-robin order plus
// hand sequences for reset, burst cap, backpressure and full-throughput cases.
module tb_mux41_rr_sched;

  logic clk = 1'b0;
  logic rst;
  logic mux_s1, mux_s0, busy;
  logic mux_s1_b, mux_s0_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux41_rr_sched_if #(.W(8)) b ();
  mux41_rr_sched_if #(.W(8)) b1 ();

  mux41_rr_sched #(.W(8), .MAX_BURST(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (b),
    .mux_s1 (mux_s1),
    .mux_s0 (mux_s0),
    .busy   (busy)
  );

  mux41_rr_sched #(.W(8), .MAX_BURST(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus    (b1),
    .mux_s1 (mux_s1_b),
    .mux_s0 (mux_s0_b),
    .busy   (busy_b)
  );

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_data;
    logic        e_last;
    logic [1:0]  e_src;
    logic        e_s1;
    logic        e_s0;
    logic        e_busy;
  } vec_t;

  vec_t tbl [11];

  always @(posedge clk) begin
    if (b.out_valid && b.out_ready)
      $display("xfer src=%0d data=%02h last=%0b", b.out_src, b.out_data, b.out_last);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pre(input string nm, input logic [3:0] rdy);
    chk({nm, ".req_ready"}, 32'(b.req_ready), 32'(rdy));
  endtask

  task automatic post(input string nm, input logic ov, input logic [7:0] data, input logic last,
                      input logic [1:0] src, input logic s1, input logic s0, input logic bz);
    chk({nm, ".out_valid"}, 32'(b.out_valid), 32'(ov));
    chk({nm, ".mux_sel"}, 32'({mux_s1, mux_s0}), 32'({s1, s0}));
    chk({nm, ".busy"}, 32'(busy), 32'(bz));
    if (ov) begin
      chk({nm, ".out_data"}, 32'(b.out_data), 32'(data));
      chk({nm, ".out_last"}, 32'(b.out_last), 32'(last));
      chk({nm, ".out_src"}, 32'(b.out_src), 32'(src));
    end
  endtask

  task automatic idle_inputs();
    b.req_valid = '0; b.req_data = '0; b.req_last = '0; b.out_ready = 1'b1;
    b1.req_valid = '0; b1.req_data = '0; b1.req_last = '0; b1.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".out_valid"}, 32'(b.out_valid), 32'd0);
    chk({nm, ".out_data"}, 32'(b.out_data), 32'd0);
    chk({nm, ".out_last"}, 32'(b.out_last), 32'd0);
    chk({nm, ".out_src"}, 32'(b.out_src), 32'd0);
    chk({nm, ".req_ready"}, 32'(b.req_ready), 32'd0);
    chk({nm, ".mux_sel"}, 32'({mux_s1, mux_s0}), 32'd0);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk_all_zero("por");

    // Round-robin with 1-beat packets; every other cycle is an arbitration bubble.
    tbl[0]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'h0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      b.req_valid = tbl[i].v;
      b.req_last  = tbl[i].l;
      b.req_data  = tbl[i].d;
      b.out_ready = tbl[i].ordy;
      #1;
      pre($sformatf("rr%0d", i), tbl[i].e_rdy);
      tick();
      post($sformatf("rr%0d", i), tbl[i].e_ov, tbl[i].e_data, tbl[i].e_last, tbl[i].e_src,
           tbl[i].e_s1, tbl[i].e_s0, tbl[i].e_busy);
    end

    // Asynchronous reset while req1 holds the grant mid-packet.
    do_reset();
    b.req_valid = 4'b0010; b.req_data = 32'h0000_2100;
    pre("rst.a", 4'b0000); tick(); post("rst.a", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    pre("rst.b", 4'b0010); tick(); post("rst.b", 1'b1, 8'h21, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    b.req_valid = 4'b0011; b.req_data = 32'h0000_2155; b.req_last = 4'b0011;
    #2 rst = 1'b1;
    #1 chk_all_zero("rst.async");
    #3 rst = 1'b0;
    tick(); post("rst.c", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    pre("rst.d", 4'b0001); tick(); post("rst.d", 1'b1, 8'h55, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); post("rst.e", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    pre("rst.f", 4'b0010); tick(); post("rst.f", 1'b1, 8'h21, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    b.req_valid = 4'b0000;
    tick(); post("rst.g", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // Burst cap of 4 on req3, then req0 gets its turn, then req3 resumes.
    do_reset();
    b.req_valid = 4'b1000; b.req_data = 32'h3000_0000;
    tick(); post("cap.g", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    b.req_valid = 4'b1001; b.req_data = 32'h3000_005A; b.req_last = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      pre($sformatf("cap%0d", n), 4'b1000);
      tick();
      post($sformatf("cap%0d", n), 1'b1, 8'h30 + 8'(n), (n == 3), 2'd3, 1'b1, 1'b1, (n < 3));
      b.req_data[31:24] = 8'h31 + 8'(n);
    end
    pre("cap.arb0", 4'b0000); tick(); post("cap.arb0", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    pre("cap.r0", 4'b0001); tick(); post("cap.r0", 1'b1, 8'h5A, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    b.req_valid = 4'b1000;
    tick(); post("cap.arb3", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    pre("cap.r3a", 4'b1000); tick(); post("cap.r3a", 1'b1, 8'h34, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
    b.req_data[31:24] = 8'h35; b.req_last = 4'b1000;
    pre("cap.r3b", 4'b1000); tick(); post("cap.r3b", 1'b1, 8'h35, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    b.req_valid = 4'b0000;
    tick(); post("cap.end", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);

    // Backpressure on a 3-beat req0 packet.
    do_reset();
    b.req_valid = 4'b0001; b.req_data = 32'h0000_0001; b.out_ready = 1'b0;
    tick(); post("bp.g", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    pre("bp.1", 4'b0001); tick(); post("bp.1", 1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    b.req_data = 32'h0000_0002;
    for (int i = 0; i < 5; i++) begin
      pre($sformatf("bp.hold%0d", i), 4'b0000);
      tick();
      post($sformatf("bp.hold%0d", i), 1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    end
    b.out_ready = 1'b1;
    #1 pre("bp.2", 4'b0001); tick(); post("bp.2", 1'b1, 8'h02, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    b.req_data = 32'h0000_0003; b.req_last = 4'b0001;
    pre("bp.3", 4'b0001); tick(); post("bp.3", 1'b1, 8'h03, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    b.req_valid = 4'b0000;
    tick(); post("bp.end", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Full throughput on a 3-beat req1 packet (ptr is 1 after the previous packet).
    b.req_valid = 4'b0010; b.req_data = 32'h0000_1100; b.req_last = 4'b0000;
    tick(); post("ft.g", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    pre("ft.1", 4'b0010); tick(); post("ft.1", 1'b1, 8'h11, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    b.req_data = 32'h0000_1200;
    pre("ft.2", 4'b0010); tick(); post("ft.2", 1'b1, 8'h12, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    b.req_data = 32'h0000_1300; b.req_last = 4'b0010;
    pre("ft.3", 4'b0010); tick(); post("ft.3", 1'b1, 8'h13, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    b.req_valid = 4'b0000;
    tick(); post("ft.end", 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // MAX_BURST=1: every beat closes its packet even with req_last low.
    b1.req_valid = 4'b0001; b1.req_data = 32'h0000_0077; b1.req_last = 4'b0000;
    tick(); chk("mb1.busy_a", 32'(busy_b), 32'd1);
    tick();
    chk("mb1.ov_a", 32'(b1.out_valid), 32'd1);
    chk("mb1.last_a", 32'(b1.out_last), 32'd1);
    chk("mb1.data_a", 32'(b1.out_data), 32'h77);
    tick();
    chk("mb1.ov_b", 32'(b1.out_valid), 32'd0);
    chk("mb1.busy_b", 32'(busy_b), 32'd1);
    tick();
    chk("mb1.ov_c", 32'(b1.out_valid), 32'd1);
    chk("mb1.last_c", 32'(b1.out_last), 32'd1);
    b1.req_valid = 4'b0000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
